// File: rtl/sp_bram_be.sv
// Single-port block RAM with byte-lane write enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear engine with busy handshake.
module sp_bram_be #(
  parameter int DATA_W         = 16,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int RD_MODE        = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     busy
);
  localparam int                NB        = DATA_W / BYTE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   r_rd_p0;
  logic                r_vld_p0;

  logic                w_in_range;
  logic                w_acc;
  logic                w_clr_we;
  logic                w_rd_upd;
  logic                w_wf;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [NB-1:0]       w_wr_be;

  generate
    if (DEPTH < (2 ** ADDR_W)) begin : g_range
      assign w_in_range = (addr < ADDR_W'(DEPTH));
    end else begin : g_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  // Requests are only honoured out of reset and while the clear engine is idle.
  assign w_acc    = en & ~r_busy & rst_n;
  assign w_clr_we = (r_state == ST_CLEAR) & rst_n;
  assign w_rd_upd = w_acc & (~we | (RD_MODE != 2));
  assign w_wf     = (RD_MODE == 1) & we;

  assign w_wr_en   = w_clr_we | (w_acc & we & w_in_range);
  assign w_wr_addr = w_clr_we ? r_clr_cnt : addr;
  assign w_wr_data = w_clr_we ? '0 : din;
  assign w_wr_be   = w_clr_we ? '1 : be;

  // Clear engine: one zero-word write per cycle, DEPTH cycles after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_busy    <= (CLEAR_ON_RESET != 0);
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Array itself carries no reset so it maps onto vendor block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr_be[i]) begin
          r_mem[w_wr_addr][i*BYTE_W +: BYTE_W] <= w_wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Stage p0: memory read register; write-first lanes bypass from din.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_p0  <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_rd_upd;
      if (w_rd_upd) begin
        for (int i = 0; i < NB; i++) begin
          if (!w_in_range) begin
            r_rd_p0[i*BYTE_W +: BYTE_W] <= '0;
          end else if (w_wf && be[i]) begin
            r_rd_p0[i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
          end else begin
            r_rd_p0[i*BYTE_W +: BYTE_W] <= r_mem[addr][i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Stage p1: optional output register, holds data between valid beats.
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] r_dout_p1;
      logic              r_vld_p1;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_dout_p1 <= '0;
          r_vld_p1  <= 1'b0;
        end else begin
          r_vld_p1 <= r_vld_p0;
          if (r_vld_p0) begin
            r_dout_p1 <= r_rd_p0;
          end
        end
      end

      assign dout       = r_dout_p1;
      assign dout_valid = r_vld_p1;
    end else begin : g_noreg
      assign dout       = r_rd_p0;
      assign dout_valid = r_vld_p0;
    end
  endgenerate

  assign busy = r_busy;

endmodule

// File: tb/tb_sp_bram_be.sv
// Bench for sp_bram_be: five parameter variants driven side by side, checked against
// a word-level memory model every cycle, plus directed vector tables and sequences.
module tb_sp_bram_be;

  localparam int NI = 5;
  localparam int DEP [NI] = '{1024, 1024, 1024, 1024, 1000};
  localparam int RDM [NI] = '{0, 1, 2, 0, 0};
  localparam int ORG [NI] = '{0, 0, 0, 1, 0};
  localparam int CLR [NI] = '{1, 1, 1, 1, 0};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NI-1:0]         en_v, we_v, dvld_v, busy_v;
  logic [NI-1:0][1:0]    be_v;
  logic [NI-1:0][9:0]    addr_v;
  logic [NI-1:0][15:0]   din_v, dout_v;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_bram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(10), .DEPTH(1024), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .we(we_v[0]), .be(be_v[0]), .addr(addr_v[0]),
    .din(din_v[0]), .dout(dout_v[0]), .dout_valid(dvld_v[0]), .busy(busy_v[0]));
  sp_bram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(10), .DEPTH(1024), .RD_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .we(we_v[1]), .be(be_v[1]), .addr(addr_v[1]),
    .din(din_v[1]), .dout(dout_v[1]), .dout_valid(dvld_v[1]), .busy(busy_v[1]));
  sp_bram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(10), .DEPTH(1024), .RD_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .we(we_v[2]), .be(be_v[2]), .addr(addr_v[2]),
    .din(din_v[2]), .dout(dout_v[2]), .dout_valid(dvld_v[2]), .busy(busy_v[2]));
  sp_bram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(10), .DEPTH(1024), .RD_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en_v[3]), .we(we_v[3]), .be(be_v[3]), .addr(addr_v[3]),
    .din(din_v[3]), .dout(dout_v[3]), .dout_valid(dvld_v[3]), .busy(busy_v[3]));
  sp_bram_be #(.DATA_W(16), .BYTE_W(8), .ADDR_W(10), .DEPTH(1000), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en_v[4]), .we(we_v[4]), .be(be_v[4]), .addr(addr_v[4]),
    .din(din_v[4]), .dout(dout_v[4]), .dout_valid(dvld_v[4]), .busy(busy_v[4]));

  // Reference model: word array with a known-flag per word, busy countdown,
  // and the response of each access delayed by the configured latency.
  logic [15:0] m_mem [NI][1024];
  bit          m_kn  [NI][1024];
  int          m_busy [NI];
  bit          p_v [NI];
  logic [15:0] p_d [NI];
  bit          p_k [NI];
  bit          e_v [NI];
  logic [15:0] e_d [NI];
  bit          e_k [NI];

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s[u%0d] got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_busy[k] = CLR[k] ? DEP[k] : 0;
        p_v[k] = 1'b0; p_d[k] = '0; p_k[k] = 1'b1;
        e_v[k] = 1'b0; e_d[k] = '0; e_k[k] = 1'b1;
      end else begin
        bit rv, rk, ov, ok;
        logic [15:0] rd, od;
        rv = 1'b0; rd = '0; rk = 1'b1;
        if (m_busy[k] > 0) begin
          m_busy[k]--;
          if (m_busy[k] == 0) begin
            for (int w = 0; w < DEP[k]; w++) begin
              m_mem[k][w] = '0;
              m_kn[k][w]  = 1'b1;
            end
          end
        end else if (en_v[k]) begin
          int a;
          bit inr, okn, nk;
          logic [15:0] old, nw;
          a   = int'(addr_v[k]);
          inr = (a < DEP[k]);
          old = inr ? m_mem[k][a] : 16'h0000;
          okn = inr ? m_kn[k][a] : 1'b1;
          if (we_v[k]) begin
            nw = old;
            if (be_v[k][0]) nw[7:0]  = din_v[k][7:0];
            if (be_v[k][1]) nw[15:8] = din_v[k][15:8];
            nk = okn || (be_v[k] == 2'b11);
            if (inr) begin
              m_mem[k][a] = nw;
              m_kn[k][a]  = nk;
            end
            if (RDM[k] == 0) begin
              rv = 1'b1; rd = old; rk = okn;
            end else if (RDM[k] == 1) begin
              rv = 1'b1; rd = inr ? nw : 16'h0000; rk = inr ? nk : 1'b1;
            end
          end else begin
            rv = 1'b1; rd = old; rk = okn;
          end
        end
        if (ORG[k] != 0) begin
          ov = p_v[k]; od = p_d[k]; ok = p_k[k];
          p_v[k] = rv; p_d[k] = rd; p_k[k] = rk;
        end else begin
          ov = rv; od = rd; ok = rk;
        end
        e_v[k] = ov;
        if (ov) begin
          e_d[k] = od;
          e_k[k] = ok;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("busy", k, 16'(busy_v[k]), 16'(m_busy[k] > 0));
      chk("dout_valid", k, 16'(dvld_v[k]), 16'(e_v[k]));
      if (e_k[k]) chk("dout", k, dout_v[k], e_d[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int          k;
    bit          we;
    logic [1:0]  be;
    logic [9:0]  a;
    logic [15:0] d;
    bit          ev;
    bit          cd;
    logic [15:0] ed;
  } vec_t;

  function automatic vec_t mk(int k, bit we, logic [1:0] be, logic [9:0] a, logic [15:0] d,
                              bit ev, bit cd, logic [15:0] ed);
    vec_t v;
    v.k = k; v.we = we; v.be = be; v.a = a; v.d = d; v.ev = ev; v.cd = cd; v.ed = ed;
    return v;
  endfunction

  int clr_cnt;

  task automatic count_busy();
    clr_cnt = 0;
    while (busy_v[0] && clr_cnt < 2000) begin
      clr_cnt++;
      en_v[0]   = 1'($urandom_range(0, 1));
      we_v[0]   = 1'b1;
      be_v[0]   = 2'b11;
      addr_v[0] = ($urandom_range(0, 1) != 0) ? 10'h010 : 10'd5;
      din_v[0]  = 16'($urandom);
      tick();
    end
    en_v[0] = 1'b0;
    chk("clear_len", 0, 16'(clr_cnt), 16'd1024);
  endtask

  initial begin
    vec_t tv[$];
    bit          sv [11];
    logic [15:0] sd [11];

    rst_n = 1'b0;
    en_v = '0; we_v = '0; be_v = '0; addr_v = '0; din_v = '0;
    tick();
    tick();
    chk("rst_busy", 0, 16'(busy_v[0]), 16'd1);
    chk("rst_busy", 4, 16'(busy_v[4]), 16'd0);
    chk("rst_dout", 0, dout_v[0], 16'h0000);
    chk("rst_vld", 3, 16'(dvld_v[3]), 16'd0);

    rst_n = 1'b1;
    count_busy();

    // Reset pulse at clear cycle 300 of a second clear; requests during busy are dropped.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      en_v[0] = 1'($urandom_range(0, 1)); we_v[0] = 1'b1; be_v[0] = 2'b11;
      addr_v[0] = 10'h010; din_v[0] = 16'($urandom);
      tick();
    end
    en_v[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy();

    tv.push_back(mk(0, 0, 2'b00, 10'd0,    16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(0, 0, 2'b00, 10'd511,  16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(0, 0, 2'b00, 10'd1023, 16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(0, 0, 2'b00, 10'h010,  16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(0, 0, 2'b00, 10'd5,    16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(0, 1, 2'b11, 10'h010,  16'hA5C3, 1, 1, 16'h0000));
    tv.push_back(mk(0, 1, 2'b01, 10'h010,  16'h00FF, 1, 1, 16'hA5C3));
    tv.push_back(mk(0, 0, 2'b00, 10'h010,  16'h0000, 1, 1, 16'hA5FF));
    tv.push_back(mk(0, 1, 2'b11, 10'd5,    16'h1111, 1, 1, 16'h0000));
    tv.push_back(mk(0, 1, 2'b11, 10'd5,    16'h2222, 1, 1, 16'h1111));
    tv.push_back(mk(0, 0, 2'b00, 10'd5,    16'h0000, 1, 1, 16'h2222));
    tv.push_back(mk(0, 1, 2'b00, 10'd6,    16'hFFFF, 1, 1, 16'h0000));
    tv.push_back(mk(0, 0, 2'b00, 10'd6,    16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(1, 1, 2'b11, 10'd5,    16'h1111, 1, 1, 16'h1111));
    tv.push_back(mk(1, 1, 2'b11, 10'd5,    16'h2222, 1, 1, 16'h2222));
    tv.push_back(mk(1, 1, 2'b01, 10'd5,    16'h00AB, 1, 1, 16'h22AB));
    tv.push_back(mk(1, 0, 2'b00, 10'd5,    16'h0000, 1, 1, 16'h22AB));
    tv.push_back(mk(2, 0, 2'b00, 10'd5,    16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(2, 1, 2'b11, 10'd5,    16'h1111, 0, 1, 16'h0000));
    tv.push_back(mk(2, 1, 2'b11, 10'd5,    16'h2222, 0, 1, 16'h0000));
    tv.push_back(mk(2, 0, 2'b00, 10'd5,    16'h0000, 1, 1, 16'h2222));
    tv.push_back(mk(2, 1, 2'b10, 10'd5,    16'h3333, 0, 1, 16'h2222));
    tv.push_back(mk(2, 0, 2'b00, 10'd5,    16'h0000, 1, 1, 16'h3322));
    tv.push_back(mk(4, 1, 2'b11, 10'd10,   16'h1234, 1, 0, 16'h0000));
    tv.push_back(mk(4, 0, 2'b00, 10'd10,   16'h0000, 1, 1, 16'h1234));
    tv.push_back(mk(4, 1, 2'b11, 10'd1010, 16'hBEEF, 1, 1, 16'h0000));
    tv.push_back(mk(4, 0, 2'b00, 10'd1010, 16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(4, 0, 2'b00, 10'd10,   16'h0000, 1, 1, 16'h1234));
    tv.push_back(mk(4, 1, 2'b11, 10'd1000, 16'hBEEF, 1, 1, 16'h0000));
    tv.push_back(mk(4, 0, 2'b00, 10'd1000, 16'h0000, 1, 1, 16'h0000));
    tv.push_back(mk(4, 1, 2'b11, 10'd999,  16'h5A5A, 1, 0, 16'h0000));
    tv.push_back(mk(4, 0, 2'b00, 10'd999,  16'h0000, 1, 1, 16'h5A5A));

    foreach (tv[i]) begin
      en_v[tv[i].k]   = 1'b1;
      we_v[tv[i].k]   = tv[i].we;
      be_v[tv[i].k]   = tv[i].be;
      addr_v[tv[i].k] = tv[i].a;
      din_v[tv[i].k]  = tv[i].d;
      tick();
      en_v[tv[i].k] = 1'b0;
      chk("tv_vld", tv[i].k, 16'(dvld_v[tv[i].k]), 16'(tv[i].ev));
      if (tv[i].cd) chk("tv_dout", tv[i].k, dout_v[tv[i].k], tv[i].ed);
    end

    // Two-cycle latency streaming on the registered-output variant.
    for (int a = 0; a < 8; a++) begin
      en_v[3] = 1'b1; we_v[3] = 1'b1; be_v[3] = 2'b11;
      addr_v[3] = 10'(a); din_v[3] = 16'h1000 + 16'(a) * 16'h0101;
      tick();
    end
    en_v[3] = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 11; i++) begin
      en_v[3] = (i < 8); we_v[3] = 1'b0; addr_v[3] = 10'(i);
      tick();
      sv[i] = dvld_v[3];
      sd[i] = dout_v[3];
    end
    en_v[3] = 1'b0;
    chk("stream_vld0", 3, 16'(sv[0]), 16'd0);
    for (int j = 1; j <= 8; j++) begin
      chk("stream_vld", 3, 16'(sv[j]), 16'd1);
      chk("stream_dout", 3, sd[j], 16'h1000 + 16'(j - 1) * 16'h0101);
    end
    chk("stream_vld9", 3, 16'(sv[9]), 16'd0);
    chk("stream_vld10", 3, 16'(sv[10]), 16'd0);
    chk("stream_hold", 3, sd[10], 16'h1707);

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        en_v[k] = ($urandom_range(0, 3) != 0);
        we_v[k] = 1'($urandom_range(0, 1));
        be_v[k] = 2'($urandom_range(0, 3));
        if (k == 4 && $urandom_range(0, 1) != 0)
          addr_v[k] = 10'($urandom_range(996, 1003));
        else
          addr_v[k] = 10'($urandom_range(0, 7));
        din_v[k] = 16'($urandom);
      end
      tick();
    end
    en_v = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
